// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART AES bridges: block geometry, bridge states
// and the default link key.
package aes_uart_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = 128;

  localparam logic [BLOCK_BITS-1:0] DEFAULT_KEY = 128'h5468617473206d79204b756e67204675;

  typedef enum logic [1:0] {
    COLLECT,
    START,
    WAIT,
    SEND
  } bridge_state_e;

endpackage

// File: rtl/byte_serializer.sv
// Loads a 128-bit block and shifts it out MSB byte first over a valid/ready
// byte interface; done pulses on the handshake of the last byte.
module byte_serializer
  import aes_uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BLOCK_BITS-1:0] load_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  done
);

  logic [BLOCK_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  fire;

  assign fire     = valid_q && tx_ready;
  assign done     = fire && (cnt_q == 4'(BLOCK_BYTES - 1));
  assign tx_data  = shreg_q[BLOCK_BITS-1 -: 8];
  assign tx_valid = valid_q;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = 4'd0;
      valid_d = 1'b1;
    end else if (fire) begin
      // Shifting only on a handshake keeps tx_data frozen during back-pressure.
      shreg_d = {shreg_q[BLOCK_BITS-9:0], 8'h00};
      cnt_d   = cnt_q + 4'd1;
      if (done) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/uart_aes_decrypt_bridge.sv
// Collects 16 ciphertext bytes, runs them through the AES decryption core and
// streams the plaintext back out byte by byte.
module uart_aes_decrypt_bridge
  import aes_uart_pkg::*;
#(
  parameter logic [BLOCK_BITS-1:0] KEY            = DEFAULT_KEY,
  parameter int unsigned           TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [BLOCK_BITS-1:0] dec_key,
  output logic [BLOCK_BITS-1:0] dec_ct,
  output logic                  dec_start,
  input  logic                  dec_done,
  input  logic [BLOCK_BITS-1:0] dec_pt,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_overrun
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES);
  // Timeout fires on the edge that would move the gap count to TIMEOUT_CYCLES-1.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 2);

  bridge_state_e         state_q, state_d;
  logic [BLOCK_BITS-1:0] in_buf_q, in_buf_d;
  logic [BLOCK_BITS-1:0] dec_ct_q, dec_ct_d;
  logic [3:0]            byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  dec_start_q, dec_start_d;
  logic                  busy_q, busy_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_overrun_q, err_overrun_d;
  logic                  ser_load;
  logic                  ser_done;

  always_comb begin
    state_d       = state_q;
    in_buf_d      = in_buf_q;
    dec_ct_d      = dec_ct_q;
    byte_cnt_d    = byte_cnt_q;
    gap_d         = gap_q;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    ser_load      = 1'b0;

    case (state_q)
      COLLECT: begin
        if (rx_valid) begin
          in_buf_d   = {in_buf_q[BLOCK_BITS-9:0], rx_data};
          byte_cnt_d = byte_cnt_q + 4'd1;
          gap_d      = '0;
          if (byte_cnt_q == 4'(BLOCK_BYTES - 1)) begin
            dec_ct_d = in_buf_d;
            state_d  = START;
          end
        end else if (byte_cnt_q != 4'd0) begin
          if (gap_q == GAP_LAST) begin
            byte_cnt_d    = 4'd0;
            gap_d         = '0;
            err_timeout_d = 1'b1;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (dec_done) begin
          ser_load = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (ser_done) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (rx_valid && (state_q != COLLECT)) begin
      err_overrun_d = 1'b1;
    end

    dec_start_d = (state_d == START);
    busy_d      = (state_d != COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      in_buf_q      <= '0;
      dec_ct_q      <= '0;
      byte_cnt_q    <= 4'd0;
      gap_q         <= '0;
      dec_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_buf_q      <= in_buf_d;
      dec_ct_q      <= dec_ct_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_q         <= gap_d;
      dec_start_q   <= dec_start_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  byte_serializer u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (dec_pt),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (ser_done)
  );

  assign dec_key     = KEY;
  assign dec_ct      = dec_ct_q;
  assign dec_start   = dec_start_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule
